fifo_wr_sched: RTL and testbench

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

---
 rtl/fifo_wr_sched_pkg.sv | 18 +
 rtl/fifo_wr_sched_if.sv | 30 +++
 rtl/fifo_wr_sched_rr_arb2.sv | 30 +++
 rtl/fifo_wr_sched.sv | 109 ++++++++++
 tb/tb_fifo_wr_sched.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and constants for the FIFO write scheduler.
// Covers the FSM state encoding, the requester indices and the default byte width.
package fifo_wr_sched_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Requester indices into the two-bit request/grant vectors
  localparam int REQ_ALU = 0;
  localparam int REQ_RF  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_RF = 2'd1,
    SEND_B0 = 2'd2,
    SEND_B1 = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Request/FIFO-write bundle between the ALU/RF requesters and the scheduler.
// The master side drives requests and the full flag; the slave side is the scheduler.
interface fifo_wr_sched_if
  import fifo_wr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                      alu_valid;
  logic [2*DATA_WIDTH-1:0]   alu_data;
  logic                      alu_ready;
  logic                      rf_valid;
  logic [DATA_WIDTH-1:0]     rf_data;
  logic                      rf_ready;
  logic                      full;
  logic                      w_inc;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      busy;

  modport master (
    output alu_valid, alu_data, rf_valid, rf_data, full,
    input  alu_ready, rf_ready, w_inc, wr_data, busy
  );

  modport slave (
    input  alu_valid, alu_data, rf_valid, rf_data, full,
    output alu_ready, rf_ready, w_inc, wr_data, busy
  );

endinterface

// File: rtl/fifo_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter: the requester granted last loses the next tie.
// The priority pointer only moves when the top reports an accepted transfer.
module rr_arb2
  import fifo_wr_sched_pkg::*;
(
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rf_prio_q;

  always_comb begin
    grant = req;
    if (&req) begin
      grant = 2'b00;
      if (rf_prio_q) grant[REQ_RF]  = 1'b1;
      else           grant[REQ_ALU] = 1'b1;
    end
  end

  // Winner of an accepted transfer hands tie priority to the other requester
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)       rf_prio_q <= 1'b0;
    else if (accept) rf_prio_q <= grant[REQ_ALU];
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Schedules one-byte RF results and two-byte ALU results into a FIFO write port.
// Requests are accepted only in IDLE; each SEND state stalls while the FIFO is full.
module fifo_wr_sched
  import fifo_wr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1
)(
  input  logic            w_clk,
  input  logic            w_rst,
  fifo_wr_sched_if.slave  bus
);

  state_t                  state_q;
  state_t                  state_d;
  logic [2*DATA_WIDTH-1:0] hold_q;

  logic [1:0]              req;
  logic [1:0]              grant;
  logic                    alu_ready;
  logic                    rf_ready;
  logic                    w_inc;
  logic                    busy;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    alu_xfer;
  logic                    rf_xfer;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   lo_byte;
  logic [DATA_WIDTH-1:0]   hi_byte;
  logic [DATA_WIDTH-1:0]   first_byte;
  logic [DATA_WIDTH-1:0]   second_byte;

  assign req = {bus.rf_valid, bus.alu_valid};

  rr_arb2 u_arb (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign alu_xfer = bus.alu_valid && alu_ready;
  assign rf_xfer  = bus.rf_valid  && rf_ready;
  assign accept   = alu_xfer || rf_xfer;

  // RF bytes are stored in both halves so IDLE can always show the second-byte slot
  assign lo_byte     = hold_q[DATA_WIDTH-1:0];
  assign hi_byte     = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign first_byte  = LSB_FIRST ? lo_byte : hi_byte;
  assign second_byte = LSB_FIRST ? hi_byte : lo_byte;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (alu_xfer)     hold_q <= bus.alu_data;
      else if (rf_xfer) hold_q <= {bus.rf_data, bus.rf_data};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (alu_xfer)     state_d = SEND_B0;
        else if (rf_xfer) state_d = SEND_RF;
      end
      SEND_RF: if (!bus.full) state_d = IDLE;
      SEND_B0: if (!bus.full) state_d = SEND_B1;
      SEND_B1: if (!bus.full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_ready = 1'b0;
    rf_ready  = 1'b0;
    w_inc     = 1'b0;
    busy      = 1'b0;
    wr_data   = second_byte;
    unique case (state_q)
      IDLE: begin
        alu_ready = grant[REQ_ALU] && !w_rst;
        rf_ready  = grant[REQ_RF]  && !w_rst;
      end
      SEND_B0: begin
        busy    = 1'b1;
        w_inc   = !bus.full;
        wr_data = first_byte;
      end
      SEND_RF, SEND_B1: begin
        busy  = 1'b1;
        w_inc = !bus.full;
      end
      default: ;
    endcase
  end

  assign bus.alu_ready = alu_ready;
  assign bus.rf_ready  = rf_ready;
  assign bus.w_inc     = w_inc;
  assign bus.wr_data   = wr_data;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Scoreboard bench for fifo_wr_sched: directed scenarios followed by random request/full traffic.
// A transaction-level model predicts grants and queues expected bytes; a monitor checks writes.
module tb_fifo_wr_sched;

  localparam int DW        = 8;
  localparam bit LSB_FIRST = 1'b1;
  localparam int DEPTH     = 4;

  logic w_clk;
  logic w_rst;

  fifo_wr_sched_if #(.DATA_WIDTH(DW)) bus ();

  fifo_wr_sched #(.DATA_WIDTH(DW), .LSB_FIRST(LSB_FIRST)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   last_byte;
  int              pend_bytes;
  bit              rf_has_prio;

  bit              alu_pend;
  bit              rf_pend;
  logic [2*DW-1:0] alu_val;
  logic [DW-1:0]   rf_val;
  bit              full_force;
  bit              use_fifo;
  int              fifo_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of the reference model: predict handshakes, check them, then commit at the edge
  task automatic stepCycle();
    bit model_idle;
    bit exp_ar;
    bit exp_rr;
    bit cur_full;
    @(negedge w_clk);
    model_idle = (pend_bytes == 0);
    exp_ar = 1'b0;
    exp_rr = 1'b0;
    if (model_idle) begin
      if (alu_pend && rf_pend) begin
        if (rf_has_prio) exp_rr = 1'b1;
        else             exp_ar = 1'b1;
      end else begin
        exp_ar = alu_pend;
        exp_rr = rf_pend;
      end
    end
    cur_full = bus.full;
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    checkOutput("rf_ready",  32'(bus.rf_ready),  32'(exp_rr));
    checkOutput("busy",      32'(bus.busy),      32'(!model_idle));
    checkOutput("w_inc",     32'(bus.w_inc),     32'(!model_idle && !cur_full));
    @(posedge w_clk);
    if (exp_ar) begin
      if (LSB_FIRST) begin
        exp_q.push_back(alu_val[DW-1:0]);
        exp_q.push_back(alu_val[2*DW-1:DW]);
      end else begin
        exp_q.push_back(alu_val[2*DW-1:DW]);
        exp_q.push_back(alu_val[DW-1:0]);
      end
      pend_bytes  = 2;
      rf_has_prio = 1'b1;
      alu_pend    = 1'b0;
    end else if (exp_rr) begin
      exp_q.push_back(rf_val);
      pend_bytes  = 1;
      rf_has_prio = 1'b0;
      rf_pend     = 1'b0;
    end else if (!model_idle && !cur_full) begin
      pend_bytes--;
      fifo_cnt++;
    end
    #1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.alu_valid = alu_pend;
      bus.alu_data  = alu_val;
      bus.rf_valid  = rf_pend;
      bus.rf_data   = rf_val;
      bus.full      = full_force || (use_fifo && fifo_cnt >= DEPTH);
      stepCycle();
    end
  endtask

  task automatic doReset();
    w_rst         = 1'b1;
    bus.alu_valid = 1'b1;
    bus.rf_valid  = 1'b1;
    bus.full      = 1'b0;
    exp_q.delete();
    pend_bytes  = 0;
    rf_has_prio = 1'b0;
    last_byte   = '0;
    alu_pend    = 1'b0;
    rf_pend     = 1'b0;
    #1;
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("rst_rf_ready",  32'(bus.rf_ready),  32'd0);
    checkOutput("rst_w_inc",     32'(bus.w_inc),     32'd0);
    checkOutput("rst_busy",      32'(bus.busy),      32'd0);
    checkOutput("rst_wr_data",   32'(bus.wr_data),   32'd0);
    repeat (2) @(posedge w_clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.rf_valid  = 1'b0;
    w_rst         = 1'b0;
  endtask

  // Monitor: every write must match the scoreboard head; idle and stalled data must hold
  always @(negedge w_clk) begin
    if (!w_rst) begin
      if (bus.w_inc) begin
        checkOutput("write_while_full", 32'(bus.full), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got %0h want no write at %0t", bus.wr_data, $time);
        end else begin
          last_byte = exp_q.pop_front();
          checkOutput("wr_data", 32'(bus.wr_data), 32'(last_byte));
        end
      end else if (!bus.busy) begin
        checkOutput("idle_hold", 32'(bus.wr_data), 32'(last_byte));
      end else if (exp_q.size() != 0) begin
        checkOutput("stall_hold", 32'(bus.wr_data), 32'(exp_q[0]));
      end
    end
  end

  initial begin
    bus.alu_data = '0;
    bus.rf_data  = '0;
    alu_val      = '0;
    rf_val       = '0;
    full_force   = 1'b0;
    use_fifo     = 1'b0;
    fifo_cnt     = 0;
    doReset();

    $display("[TB] single RF byte");
    rf_val = 8'hA5; rf_pend = 1'b1;
    applyStimulus(4);

    $display("[TB] ALU two-byte write");
    alu_val = 16'h1234; alu_pend = 1'b1;
    applyStimulus(5);

    $display("[TB] simultaneous requests after reset");
    doReset();
    alu_val = 16'h5678; rf_val = 8'h9C; alu_pend = 1'b1; rf_pend = 1'b1;
    applyStimulus(8);
    alu_val = 16'hCAFE; rf_val = 8'h3D; alu_pend = 1'b1; rf_pend = 1'b1;
    applyStimulus(8);

    $display("[TB] stall between ALU bytes");
    alu_val = 16'hBEEF; alu_pend = 1'b1;
    applyStimulus(2);
    full_force = 1'b1;
    applyStimulus(5);
    full_force = 1'b0;
    applyStimulus(3);

    $display("[TB] reset during second ALU byte");
    alu_val = 16'h1234; alu_pend = 1'b1;
    applyStimulus(2);
    doReset();
    rf_val = 8'h5A; rf_pend = 1'b1;
    applyStimulus(4);

    $display("[TB] random traffic with FIFO fill model");
    use_fifo = 1'b1;
    fifo_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      if (!alu_pend && ($urandom % 3 == 0)) begin
        alu_pend = 1'b1;
        alu_val  = 16'($urandom);
      end
      if (!rf_pend && ($urandom % 3 == 0)) begin
        rf_pend = 1'b1;
        rf_val  = 8'($urandom);
      end
      if (fifo_cnt > 0 && ($urandom % 2 == 0)) fifo_cnt--;
      full_force = ($urandom % 6 == 0);
      applyStimulus(1);
    end
    use_fifo   = 1'b0;
    full_force = 1'b0;
    applyStimulus(12);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
